ufm_ctrl: RTL

//   Host-side sequencer for the 512x16 user flash (UFM) serial port. Accepts single-word

---
 rtl/ufm_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ufm_ctrl.sv
// ufm_ctrl: host-side sequencer for the 512x16 user flash serial port.
// Turns single-word read/program requests into arclk/ardin/arshft and
// drclk/drdin/drshft/prgram sequences. Reads at last_addr+1 reuse the UFM
// address counter (one increment pulse) instead of reshifting the address.
//
// Handshake: a request is taken on any cycle where busy=0 and req_rd|req_wr
// is high (req_wr wins if both); requests seen while busy=1 are dropped, not
// queued. Completion is a one-cycle done pulse, and rdata holds the word of
// the most recent completed read.
module ufm_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int PROG_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [8:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        oscena,
  output logic        arclk,
  output logic        ardin,
  output logic        arshft,
  output logic        drclk,
  output logic        drdin,
  output logic        drshft,
  input  logic        drdout,
  output logic        prgram,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_INC, S_LOAD, S_SHIFT, S_WDATA, S_PROG, S_DONE
  } state_t;

  // One tick is 2*CLK_DIV cycles; the serial clock is high in its second half.
  localparam logic [15:0] TICK_LAST = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] CLK_RISE  = 16'(CLK_DIV);
  localparam logic [15:0] PROG_LAST = 16'(PROG_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [3:0]  bitc, bitc_d;
  logic [8:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [15:0] sreg, sreg_nx;
  logic [8:0]  last_addr;
  logic        seq_valid;
  logic        sample, tick_end;
  logic        in_ar, in_dr, clk_hi;
  logic [3:0]  ar_idx, dr_idx;
  logic        arclk_d, ardin_d, arshft_d, drclk_d, drdin_d, drshft_d, prgram_d;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign oscena    = 1'b0;
  assign dbg_state = state;
  assign tick_end  = (cnt == TICK_LAST);
  assign sreg_nx   = {sreg[14:0], drdout};

  // Next-state logic: tick/bit counters, request capture, read-data sampling.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bitc_d  = bitc;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    sample  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          wr_d    = req_wr;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          bitc_d  = '0;
          if (!req_wr && seq_valid && (addr == last_addr + 9'd1)) state_d = S_INC;
          else                                                    state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (tick_end) begin
          cnt_d = '0;
          if (bitc == 4'd8) begin
            bitc_d  = '0;
            state_d = wr_q ? S_WDATA : S_LOAD;
          end else begin
            bitc_d = bitc + 4'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_INC: begin
        if (tick_end) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_LOAD: begin
        if (tick_end) begin
          sample  = 1'b1;
          cnt_d   = '0;
          bitc_d  = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_SHIFT: begin
        if (tick_end) begin
          sample = 1'b1;
          cnt_d  = '0;
          if (bitc == 4'd14) begin
            bitc_d  = '0;
            state_d = S_DONE;
          end else begin
            bitc_d = bitc + 4'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_WDATA: begin
        if (tick_end) begin
          cnt_d = '0;
          if (bitc == 4'd15) begin
            bitc_d  = '0;
            state_d = S_PROG;
          end else begin
            bitc_d = bitc + 4'd1;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_PROG: begin
        if (cnt == PROG_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serial pin values for the next cycle, so every pin comes straight off a flop.
  always_comb begin
    in_ar    = (state_d == S_ADDR) || (state_d == S_INC);
    in_dr    = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_WDATA);
    clk_hi   = (cnt_d >= CLK_RISE);
    ar_idx   = 4'd8 - bitc_d;
    dr_idx   = 4'd15 - bitc_d;
    arclk_d  = in_ar && clk_hi;
    ardin_d  = (state_d == S_ADDR) && addr_d[ar_idx];
    arshft_d = (state_d == S_ADDR);
    drclk_d  = in_dr && clk_hi;
    drdin_d  = (state_d == S_WDATA) && wdata_d[dr_idx];
    drshft_d = (state_d == S_SHIFT) || (state_d == S_WDATA);
    prgram_d = (state_d == S_PROG);
  end

  // FSM state, counters and captured request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bitc    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bitc    <= bitc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  // Registered UFM pins; reset drops clocks and prgram immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arclk  <= 1'b0;
      ardin  <= 1'b0;
      arshft <= 1'b0;
      drclk  <= 1'b0;
      drdin  <= 1'b0;
      drshft <= 1'b0;
      prgram <= 1'b0;
    end else begin
      arclk  <= arclk_d;
      ardin  <= ardin_d;
      arshft <= arshft_d;
      drclk  <= drclk_d;
      drdin  <= drdin_d;
      drshft <= drshft_d;
      prgram <= prgram_d;
    end
  end

  // Read shift register, result publish, and sequential-address tracking.
  // rdata is loaded with the final sample so it is valid during the done cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      rdata     <= '0;
      last_addr <= '0;
      seq_valid <= 1'b0;
    end else begin
      if (sample) sreg <= sreg_nx;
      if ((state == S_SHIFT) && (state_d == S_DONE)) begin
        rdata     <= sreg_nx;
        last_addr <= addr_q;
        seq_valid <= 1'b1;
      end
      if ((state == S_PROG) && (state_d == S_DONE)) seq_valid <= 1'b0;
    end
  end

endmodule
